id_issue_queue: RTL and testbench

//  Parametrised decode->issue buffer; generalises the single ID/issue pipeline register to Depth entries.

---
 rtl/id_issue_queue.sv | 106 ++++++++++
 tb/tb_id_issue_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_queue.sv
// Decode->issue FIFO of scoreboard entries with a cap on queued control flow.
// Define ID_QUEUE_BYPASS_EN for a same-cycle path from an empty queue to issue.
module id_issue_queue #(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned Depth       = 4,
  parameter int unsigned MaxCtrlFlow = 1,
  parameter int unsigned CntW        = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 ctrl_flow_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 ctrl_flow_o,
  output logic                 valid_o,
  input  logic                 ack_i,
  output logic [CntW-1:0]      count_o,
  output logic [CntW-1:0]      cf_count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);
  localparam logic [CntW-1:0] MaxCfC = CntW'(MaxCtrlFlow);
  localparam logic [PtrW-1:0] LastP  = PtrW'(Depth - 1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [Depth-1:0]     cf_q;
  logic [PtrW-1:0]      rd_q, wr_q;
  logic [CntW-1:0]      cnt_q, cf_cnt_q;
  logic [CntW-1:0]      cnt_d, cf_cnt_d;

  logic q_valid, head_cf, pop_q;
  logic cf_ok, space, wr_en, byp_take;
  logic [DataWidth-1:0] head_data;

  assign q_valid   = (cnt_q != '0);
  assign head_cf   = cf_q[rd_q];
  assign head_data = mem_q[rd_q];

  // Only a queued head can be popped; a bypassed entry never enters storage.
  assign pop_q = rst_ni & ack_i & q_valid & ~flush_i;
  assign cf_ok = ~ctrl_flow_i | (cf_cnt_q < MaxCfC) | (pop_q & head_cf);
  assign space = (cnt_q < DepthC) | pop_q;

  assign ready_o = rst_ni & valid_i & space & cf_ok & ~flush_i;

`ifdef ID_QUEUE_BYPASS_EN
  logic byp_v;
  assign byp_v       = rst_ni & valid_i & ~flush_i & ~q_valid & cf_ok;
  assign byp_take    = byp_v & ack_i;
  assign valid_o     = rst_ni & (q_valid | byp_v);
  assign data_o      = byp_v ? data_i : head_data;
  assign ctrl_flow_o = byp_v ? ctrl_flow_i : head_cf;
`else
  assign byp_take    = 1'b0;
  assign valid_o     = rst_ni & q_valid;
  assign data_o      = head_data;
  assign ctrl_flow_o = head_cf;
`endif

  assign wr_en = ready_o & ~byp_take;

  assign cnt_d    = cnt_q + CntW'(wr_en) - CntW'(pop_q);
  assign cf_cnt_d = cf_cnt_q + CntW'(wr_en & ctrl_flow_i)
                  - CntW'(pop_q & head_cf);

  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return (p == LastP) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      cf_cnt_q <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      cf_q     <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      cnt_q    <= '0;
      cf_cnt_q <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= data_i;
        cf_q[wr_q]  <= ctrl_flow_i;
        wr_q        <= inc(wr_q);
      end
      if (pop_q) begin
        rd_q <= inc(rd_q);
      end
      cnt_q    <= cnt_d;
      cf_cnt_q <= cf_cnt_d;
    end
  end

  assign count_o    = cnt_q;
  assign cf_count_o = cf_cnt_q;

endmodule

// File: tb/tb_id_issue_queue.sv
// Scoreboard bench for id_issue_queue (Depth=4, MaxCtrlFlow=1).
// Stimulus queues expected pops; a monitor checks every acked head.
module tb_id_issue_queue;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        ctrl_flow_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ack_i = 1'b0;
  logic        ready_o;
  logic [15:0] data_o;
  logic        ctrl_flow_o;
  logic        valid_o;
  logic [2:0]  count_o;
  logic [2:0]  cf_count_o;

  int total = 0;
  int bad = 0;
  int pops = 0;
  logic [16:0] sb [$];

  always #5 clk = ~clk;

  id_issue_queue #(
    .DataWidth(16),
    .Depth(4),
    .MaxCtrlFlow(1)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .flush_i(flush_i),
    .data_i(data_i),
    .ctrl_flow_i(ctrl_flow_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o(data_o),
    .ctrl_flow_o(ctrl_flow_o),
    .valid_o(valid_o),
    .ack_i(ack_i),
    .count_o(count_o),
    .cf_count_o(cf_count_o)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] d,
                        input logic cf, input logic a, input logic f);
    valid_i = v;
    data_i = d;
    ctrl_flow_i = cf;
    ack_i = a;
    flush_i = f;
  endtask

  // Called at the negedge: record what the DUT accepts this cycle.
  task automatic nxt();
    if (!rst_ni || flush_i) sb.delete();
    else if (ready_o) sb.push_back({ctrl_flow_i, data_i});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input logic a);
    set_in(1'b0, 16'h0, 1'b0, a, 1'b0);
    @(negedge clk);
    nxt();
  endtask

  // Monitor: compare every acked head against the scoreboard front.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_ni && !flush_i && valid_o && ack_i) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", 32'(data_o), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("pop_data", 32'(data_o), 32'(e[15:0]));
          chk("pop_cf", 32'(ctrl_flow_o), 32'(e[16]));
          pops++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int pushed;
    int p0;
    int cyc;
    logic [9:0] ackpat;
    ackpat = 10'b1011001101;

    // Reset held two cycles with valid_i high.
    set_in(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_cf", 32'(cf_count_o), 0);
    nxt();
    rst_ni = 1'b1;

    // Fill A..D.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'h00A0 + 16'(i), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("fill_ready", 32'(ready_o), 1);
      nxt();
    end
    set_in(1'b1, 16'h00A4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", 32'(count_o), 4);
    chk("full_ready", 32'(ready_o), 0);
    chk("full_valid", 32'(valid_o), 1);
    nxt();
    set_in(1'b1, 16'h00A4, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("full_pp_ready", 32'(ready_o), 1);
    nxt();
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_pp_count", 32'(count_o), 4);
    nxt();
    repeat (4) idle_cyc(1'b1);
    @(negedge clk);
    chk("drain_count", 32'(count_o), 0);
    chk("drain_pops", 32'(pops), 5);
    nxt();

    // Order and pointer wrap with a fixed ack pattern.
    pushed = 0;
    p0 = pops;
    cyc = 0;
    while ((pushed < 10 || count_o != 0) && cyc < 60) begin
      set_in(pushed < 10, 16'h0B00 + 16'(pushed), 1'b0,
             (pushed < 10) ? ackpat[cyc % 10] : 1'b1, 1'b0);
      @(negedge clk);
      if (ready_o) pushed++;
      nxt();
      cyc++;
    end
    @(negedge clk);
    chk("wrap_done", 32'(cyc < 60), 1);
    chk("wrap_pops", 32'(pops - p0), 10);
    nxt();

    // Control-flow cap.
    set_in(1'b1, 16'h00B1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("cf_b1_ready", 32'(ready_o), 1);
    nxt();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 16'h00B2, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("cf_b2_block", 32'(ready_o), 0);
      chk("cf_cnt_1", 32'(cf_count_o), 1);
      nxt();
    end
    set_in(1'b1, 16'h00B2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("cf_b2_accept", 32'(ready_o), 1);
    nxt();
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cf_cnt_after", 32'(cf_count_o), 1);
    chk("cf_count_after", 32'(count_o), 1);
    nxt();
    idle_cyc(1'b1);
    @(negedge clk);
    chk("cf_drained", 32'(cf_count_o), 0);
    nxt();

    // Flush with three held entries.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 16'h00C0 + 16'(i), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      nxt();
    end
    set_in(1'b1, 16'h00C3, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("fl_count_pre", 32'(count_o), 3);
    chk("fl_ready", 32'(ready_o), 0);
    nxt();
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_count", 32'(count_o), 0);
    chk("fl_valid", 32'(valid_o), 0);
    chk("fl_cf", 32'(cf_count_o), 0);
    nxt();

    // Empty queue, push with ack in the same cycle.
    set_in(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("byp_ready", 32'(ready_o), 1);
`ifdef ID_QUEUE_BYPASS_EN
    chk("byp_valid", 32'(valid_o), 1);
    chk("byp_data", 32'(data_o), 32'hDEAD);
    nxt();
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("byp_count", 32'(count_o), 0);
    chk("byp_valid2", 32'(valid_o), 0);
    nxt();
`else
    chk("nobyp_valid", 32'(valid_o), 0);
    nxt();
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("nobyp_valid2", 32'(valid_o), 1);
    chk("nobyp_data", 32'(data_o), 32'hDEAD);
    nxt();
    @(negedge clk);
    chk("nobyp_count", 32'(count_o), 0);
    nxt();
`endif

    // Reset mid-operation.
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 16'h00E0 + 16'(i), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      nxt();
    end
    rst_ni = 1'b0;
    set_in(1'b1, 16'h00E2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mrst_ready", 32'(ready_o), 0);
    chk("mrst_valid", 32'(valid_o), 0);
    nxt();
    rst_ni = 1'b1;
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mrst_count", 32'(count_o), 0);
    chk("mrst_cf", 32'(cf_count_o), 0);
    chk("mrst_data", 32'(data_o), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    nxt();

    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
